// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid scheduler: tag layout, FSM states, Q-format helpers.
package sigmoid_pkg;

  localparam int unsigned SIG_LATENCY_DEF = 1;
  localparam int unsigned MAX_REQ         = 256;

  // Q16.16 reference constants
  localparam logic [31:0] ONE       = 32'h0001_0000;
  localparam logic [31:0] FLOAT_0_5 = 32'h0000_8000;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned TAG_ID_W = id_width(MAX_REQ);

  typedef enum logic {IDLE, LOCK} sched_state_e;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sigmoid_scheduler_rr_arbiter.sv
// Pointer-rotated first-valid picker: grants the first set req bit at or after ptr, cyclically.
module rr_arbiter
  import sigmoid_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] idx;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan farthest offset first so the nearest valid requester overwrites and wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = wrap_add(ptr, N - 1 - i);
      if (req[idx]) begin
        gnt    = N'(1) << idx;
        gnt_id = idx;
      end
    end
  end

endmodule

// File: rtl/sigmoid_scheduler.sv
// Shares one pipelined sigmoid unit among several requesters with round-robin + burst-lock arbitration,
// tagging each issue so the result returns with its requester id after the unit's fixed latency.
module sigmoid_scheduler
  import sigmoid_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH  = 32,
  parameter int unsigned pFRAC_NUM    = 16,
  parameter int unsigned pNUM_REQ     = 4,
  parameter int unsigned pMAX_BURST   = 4,
  parameter int unsigned pSIG_LATENCY = SIG_LATENCY_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [pNUM_REQ-1:0]             req_valid,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0] req_data,
  output logic [pNUM_REQ-1:0]             req_ready,
  output logic                            sig_rst,
  output logic                            sig_en,
  output logic [pDATA_WIDTH-1:0]          sig_din,
  input  logic [pDATA_WIDTH-1:0]          sig_dout,
  output logic [pNUM_REQ-1:0]             rsp_valid,
  output logic [$clog2(pNUM_REQ)-1:0]     rsp_id,
  output logic [pDATA_WIDTH-1:0]          rsp_data,
  output logic                            busy
);

  localparam int unsigned IW = id_width(pNUM_REQ);
  localparam int unsigned BW = $clog2(pMAX_BURST + 1);
  localparam int unsigned LL = pSIG_LATENCY - 1;

  if (pNUM_REQ < 2 || pMAX_BURST < 1 || pSIG_LATENCY < 1 || pFRAC_NUM >= pDATA_WIDTH) begin : g_bad_cfg
    $error("sigmoid_scheduler: illegal parameter set");
  end

  sched_state_e            state_q, state_d;
  logic [IW-1:0]           owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]           owner_nxt, arb_ptr, pick_id, gnt_id;
  logic [BW-1:0]           burst_q, burst_d;
  logic [pNUM_REQ-1:0]     pick_gnt, gnt;
  logic                    hold, issue, tags_v, rst_arm_q;
  logic [pDATA_WIDTH-1:0]  din_q, operand;
  tag_t                    tag_q [pSIG_LATENCY];

  assign owner_nxt = (owner_q == IW'(pNUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  // After a lock releases, the next pick starts just past the old owner in the same cycle.
  assign arb_ptr   = (state_q == LOCK) ? owner_nxt : rr_ptr_q;
  assign hold      = (state_q == LOCK) && req_valid[owner_q] && (burst_q < BW'(pMAX_BURST));

  rr_arbiter #(.N(pNUM_REQ), .IW(IW)) u_arb (
    .req    (req_valid),
    .ptr    (arb_ptr),
    .gnt    (pick_gnt),
    .gnt_id (pick_id)
  );

  // Arbitration FSM: next state and grant.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    gnt      = '0;
    gnt_id   = '0;
    if (!sig_rst) begin
      if (state_q == LOCK && hold) begin
        gnt     = pNUM_REQ'(1) << owner_q;
        gnt_id  = owner_q;
        burst_d = burst_q + BW'(1);
      end else begin
        if (state_q == LOCK) rr_ptr_d = owner_nxt;
        if (|pick_gnt) begin
          gnt     = pick_gnt;
          gnt_id  = pick_id;
          state_d = LOCK;
          owner_d = pick_id;
          burst_d = BW'(1);
        end else begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
    end
  end

  assign issue     = |gnt;
  assign req_ready = gnt;
  assign operand   = req_data[int'(gnt_id) * int'(pDATA_WIDTH) +: pDATA_WIDTH];
  assign sig_din   = issue ? operand : din_q;
  assign sig_en    = issue | tags_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
      din_q     <= '0;
      rst_arm_q <= 1'b0;
      sig_rst   <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      burst_q   <= burst_d;
      rst_arm_q <= 1'b1;
      sig_rst   <= ~rst_arm_q;
      if (issue) din_q <= operand;
    end
  end

  // Tag pipe advances in lockstep with the sigmoid enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < pSIG_LATENCY; i++) tag_q[i] <= '0;
    end else if (sig_en) begin
      tag_q[0].v  <= issue;
      tag_q[0].id <= TAG_ID_W'(gnt_id);
      for (int unsigned i = 1; i < pSIG_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    tags_v    = 1'b0;
    rsp_valid = '0;
    for (int unsigned i = 0; i < pSIG_LATENCY; i++) tags_v = tags_v | tag_q[i].v;
    for (int unsigned i = 0; i < pNUM_REQ; i++)
      rsp_valid[i] = tag_q[LL].v && (tag_q[LL].id == TAG_ID_W'(i));
  end

  assign rsp_id   = IW'(tag_q[LL].id);
  assign rsp_data = tag_q[LL].v ? sig_dout : '0;
  assign busy     = ~sig_rst & ((|req_valid) | tags_v);

endmodule
